pooling_sequencer: RTL and testbench
====================================

// Module: pooling_sequencer
// PURPOSE
//  Sequences 2x2 average pooling of one IMG_W x IMG_H frame held in a synchronous-read source RAM.
//  - Fetches each 2x2 window and presents it to one shared, external, combinational pixels_averaging unit.
//  - Writes each averaged pixel to a destination RAM in raster order.
//  - Sits between the input frame buffer and the classifier input buffer, replacing a fully parallel pooling array.
// PARAMETERS
//  RESOLUTION  8   bits per pixel
//  IMG_W       28  source width in pixels (even, >=2)
//  IMG_H       28  source height in pixels (even, >=2)
//  SRC_AW      $clog2(IMG_W*IMG_H)     source address width (derived localparam)
//  DST_AW      $clog2(IMG_W*IMG_H/4)   destination address width (derived localparam)
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high reset
//  start        in   1           1-cycle pulse; begins one frame when idle
//  busy         out  1           high while a frame is in progress
//  done         out  1           1-cycle pulse after the last write
//  src_rd_en    out  1           source RAM read strobe
//  src_rd_addr  out  SRC_AW      source read address; data valid the next cycle
//  src_rd_data  in   RESOLUTION  source read data (1-cycle latency)
//  avg_in1..4   out  RESOLUTION  registered top-left, top-right, bottom-left, bottom-right window pixels
//  avg_out      in   RESOLUTION  combinational result of the shared averaging unit
//  dst_wr_en    out  1           destination write strobe
//  dst_wr_addr  out  DST_AW      destination address = r*(IMG_W/2)+c
//  dst_wr_data  out  RESOLUTION  equals avg_out during a write
//  dst_ready    in   1           destination can accept a write (present only with the macro)
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, src_rd_en, dst_wr_en = 0; all addresses, avg_in1..4, and window counters r, c = 0.
//    Asserting reset mid-frame aborts the frame; no done pulse is produced.
//  - FSM states and transitions:
//    - IDLE: on start -> RD with k=0, r=0, c=0; busy rises the next cycle.
//    - RD (4 cycles, k=0..3): src_rd_en=1 and src_rd_addr = base+{0, 1, IMG_W, IMG_W+1}[k],
//      where base = 2r*IMG_W + 2c. Data returned for read k-1 is registered into avg_in{k}.
//    - WAIT (1 cycle): src_rd_en=0; registers avg_in4 from the read issued at k=3.
//    - WR: dst_wr_en=1 and dst_wr_data=avg_out.
//      On completion: if the window is the last -> DONE; else advance c, wrapping c to 0 and incrementing r
//      at c=IMG_W/2-1, and -> RD.
//    - DONE (1 cycle): done=1, busy=0 -> IDLE.
//  - Cadence and latency: 6 cycles per window. A frame is (IMG_W*IMG_H/4)*6 cycles from the first RD cycle
//    to the last WR cycle; the default 28x28 frame takes 1176 cycles. done occurs 1 cycle after the last WR.
//  - start while busy or in DONE is ignored. start coincident with reset is ignored.
//  - avg_in1..4 hold their last values between windows and after the frame. The averaging rule (sum/4,
//    truncated) is owned by the external unit; the sequencer does no arithmetic on pixel data.
//  - Counter widths are sized so r and c never wrap within a frame. IMG_W or IMG_H odd -> elaboration error.
// CONFIGURATION
//  POOL_BACKPRESSURE_EN
//  - Defined: dst_ready exists.
//    - In WR, a write completes only on dst_wr_en && dst_ready.
//    - Otherwise WR holds, with dst_wr_en, dst_wr_addr and dst_wr_data stable. avg_in1..4 are also held
//      stable, so avg_out is stable.
//    - Cycle counts above grow by the number of stall cycles.
//  - Undefined: no dst_ready port; every WR completes in 1 cycle.
// TESTING (IMG_W=IMG_H=4; src RAM holds mem[a]=a; bench models avg_out=(in1+in2+in3+in4)>>2)
//  1. Basic frame: start pulse.
//     -> Writes (addr, data) = (0,2), (1,4), (2,10), (3,12) in that order.
//     -> done 24 cycles after the first RD cycle; busy then low.
//  2. Read order: same frame.
//     -> src_rd_addr sequence 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
//     -> Exactly 16 reads and 4 writes.
//  3. start while busy: pulse start at cycles 3 and 10 of a frame.
//     -> Behaviour and write trace identical to scenario 1; a single done.
//  4. Reset mid-frame: assert reset during the second window's RD.
//     -> All outputs 0 immediately; no done pulse.
//     -> A new start afterwards reproduces scenario 1 exactly.
//  5. Backpressure (POOL_BACKPRESSURE_EN): hold dst_ready low 3 cycles at the first WR.
//     -> dst_wr_en=1, addr=0, data=2 stable throughout; a single write of (0,2) on release.
//     -> done delayed by 3 cycles.
//  6. Default 28x28 with mem[a]=a mod 256: start.
//     -> 196 writes.
//     -> Last write addr 195, data = (754+755+782+783)>>2 mod-256 inputs = (242+243+14+15)>>2 = 128.
//     -> done 1177 cycles after start is sampled.

Source files
------------

// File: rtl/pooling_sequencer.sv
// Sequences 2x2 average pooling of one IMG_W x IMG_H frame from a sync-read RAM through a shared external averager.
// Latency: 6 cycles per window (4 reads, 1 data wait, 1 write); done pulses 1 cycle after the last write.
// Backpressure: with POOL_BACKPRESSURE_EN defined, WR holds until dst_ready; otherwise every write completes at once.
module pooling_sequencer #(
    parameter int RESOLUTION = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    localparam int SRC_AW    = $clog2(IMG_W*IMG_H),
    localparam int DST_AW    = (IMG_W*IMG_H/4 > 1) ? $clog2(IMG_W*IMG_H/4) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd_en,
    output logic [SRC_AW-1:0]     src_rd_addr,
    input  logic [RESOLUTION-1:0] src_rd_data,
    output logic [RESOLUTION-1:0] avg_in1,
    output logic [RESOLUTION-1:0] avg_in2,
    output logic [RESOLUTION-1:0] avg_in3,
    output logic [RESOLUTION-1:0] avg_in4,
    input  logic [RESOLUTION-1:0] avg_out,
`ifdef POOL_BACKPRESSURE_EN
    input  logic                  dst_ready,
`endif
    output logic                  dst_wr_en,
    output logic [DST_AW-1:0]     dst_wr_addr,
    output logic [RESOLUTION-1:0] dst_wr_data
);

    localparam int CW = $clog2(IMG_W/2 + 1);
    localparam int RW = $clog2(IMG_H/2 + 1);
    localparam logic [CW-1:0]     C_LAST   = CW'(IMG_W/2 - 1);
    localparam logic [RW-1:0]     R_LAST   = RW'(IMG_H/2 - 1);
    localparam logic [SRC_AW-1:0] ROW_OFF  = SRC_AW'(IMG_W);
    localparam logic [SRC_AW-1:0] ROW_STEP = SRC_AW'(IMG_W + 2);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
        $error("pooling_sequencer: IMG_W and IMG_H must be even and at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t            state;
    logic [1:0]        k;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic [SRC_AW-1:0] base;
    logic              wr_fire;

    function automatic logic [SRC_AW-1:0] win_off(input logic [1:0] idx);
        case (idx)
            2'd0:    win_off = '0;
            2'd1:    win_off = SRC_AW'(1);
            2'd2:    win_off = ROW_OFF;
            default: win_off = ROW_OFF + SRC_AW'(1);
        endcase
    endfunction

`ifdef POOL_BACKPRESSURE_EN
    assign wr_fire = dst_wr_en && dst_ready;
`else
    assign wr_fire = dst_wr_en;
`endif

    // The averager is combinational on the registered window, so its result is the write data directly.
    assign dst_wr_data = avg_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= '0;
            r           <= '0;
            c           <= '0;
            base        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            src_rd_en   <= 1'b0;
            src_rd_addr <= '0;
            avg_in1     <= '0;
            avg_in2     <= '0;
            avg_in3     <= '0;
            avg_in4     <= '0;
            dst_wr_en   <= 1'b0;
            dst_wr_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RD;
                        k           <= '0;
                        r           <= '0;
                        c           <= '0;
                        base        <= '0;
                        busy        <= 1'b1;
                        src_rd_en   <= 1'b1;
                        src_rd_addr <= '0;
                        dst_wr_addr <= '0;
                    end
                end
                S_RD: begin
                    // Data returned now belongs to the read issued in the previous cycle.
                    case (k)
                        2'd1:    avg_in1 <= src_rd_data;
                        2'd2:    avg_in2 <= src_rd_data;
                        2'd3:    avg_in3 <= src_rd_data;
                        default: ;
                    endcase
                    if (k == 2'd3) begin
                        state     <= S_WAIT;
                        src_rd_en <= 1'b0;
                    end else begin
                        k           <= k + 2'd1;
                        src_rd_addr <= base + win_off(k + 2'd1);
                    end
                end
                S_WAIT: begin
                    avg_in4   <= src_rd_data;
                    state     <= S_WR;
                    dst_wr_en <= 1'b1;
                end
                S_WR: begin
                    if (wr_fire) begin
                        dst_wr_en <= 1'b0;
                        if (r == R_LAST && c == C_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= S_RD;
                            k           <= '0;
                            src_rd_en   <= 1'b1;
                            dst_wr_addr <= dst_wr_addr + DST_AW'(1);
                            if (c == C_LAST) begin
                                c           <= '0;
                                r           <= r + RW'(1);
                                base        <= base + ROW_STEP;
                                src_rd_addr <= base + ROW_STEP;
                            end else begin
                                c           <= c + CW'(1);
                                base        <= base + SRC_AW'(2);
                                src_rd_addr <= base + SRC_AW'(2);
                            end
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_sequencer.sv
// Bench for pooling_sequencer: a 4x4 instance with a RAM/averager model and a default 28x28 instance.
module tb_pooling_sequencer;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic start_b   = 1'b0;
    logic dst_ready = 1'b1;

    logic       busy_s, done_s, src_rd_en_s, dst_wr_en_s;
    logic [3:0] src_rd_addr_s;
    logic [1:0] dst_wr_addr_s;
    logic [7:0] src_rd_data_s, a1_s, a2_s, a3_s, a4_s, avg_out_s, dst_wr_data_s;

    logic       busy_b, done_b, src_rd_en_b, dst_wr_en_b;
    logic [9:0] src_rd_addr_b;
    logic [7:0] dst_wr_addr_b;
    logic [7:0] src_rd_data_b, a1_b, a2_b, a3_b, a4_b, avg_out_b, dst_wr_data_b;

    logic [7:0] mem_s [W*H];

    pooling_sequencer #(.RESOLUTION(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy_s), .done(done_s),
        .src_rd_en(src_rd_en_s), .src_rd_addr(src_rd_addr_s), .src_rd_data(src_rd_data_s),
        .avg_in1(a1_s), .avg_in2(a2_s), .avg_in3(a3_s), .avg_in4(a4_s), .avg_out(avg_out_s),
`ifdef POOL_BACKPRESSURE_EN
        .dst_ready(dst_ready),
`endif
        .dst_wr_en(dst_wr_en_s), .dst_wr_addr(dst_wr_addr_s), .dst_wr_data(dst_wr_data_s)
    );

    pooling_sequencer dut_big (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .src_rd_en(src_rd_en_b), .src_rd_addr(src_rd_addr_b), .src_rd_data(src_rd_data_b),
        .avg_in1(a1_b), .avg_in2(a2_b), .avg_in3(a3_b), .avg_in4(a4_b), .avg_out(avg_out_b),
`ifdef POOL_BACKPRESSURE_EN
        .dst_ready(1'b1),
`endif
        .dst_wr_en(dst_wr_en_b), .dst_wr_addr(dst_wr_addr_b), .dst_wr_data(dst_wr_data_b)
    );

    // External averaging units and source RAMs (1-cycle read latency).
    assign avg_out_s = 8'((10'(a1_s) + 10'(a2_s) + 10'(a3_s) + 10'(a4_s)) >> 2);
    assign avg_out_b = 8'((10'(a1_b) + 10'(a2_b) + 10'(a3_b) + 10'(a4_b)) >> 2);
    always @(posedge clk) if (src_rd_en_s) src_rd_data_s <= mem_s[src_rd_addr_s];
    always @(posedge clk) if (src_rd_en_b) src_rd_data_b <= src_rd_addr_b[7:0];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_q[$], wa_q[$], wd_q[$];
    int first_rd, done_n, done_cyc;
    logic busy_at_done;
    int wa_b[$], wd_b[$];
    int done_n_b, done_cyc_b;

    always @(negedge clk) begin
        if (src_rd_en_s) begin
            rd_q.push_back(int'(src_rd_addr_s));
            if (first_rd < 0) first_rd = cyc;
        end
        if (dst_wr_en_s && dst_ready) begin
            wa_q.push_back(int'(dst_wr_addr_s));
            wd_q.push_back(int'(dst_wr_data_s));
        end
        if (done_s) begin
            done_n++;
            done_cyc = cyc;
            busy_at_done = busy_s;
        end
        if (dst_wr_en_b) begin
            wa_b.push_back(int'(dst_wr_addr_b));
            wd_b.push_back(int'(dst_wr_data_b));
        end
        if (done_b) begin
            done_n_b++;
            done_cyc_b = cyc;
        end
    end

    int exp_rd[$], exp_wa[$], exp_wd[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        first_rd = -1; done_n = 0; done_cyc = -1; busy_at_done = 1'bx;
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick;
            if (done_n > 0) seen = 1'b1;
        end
        tick;
    endtask

    task automatic fill_ident;
        for (int a = 0; a < W*H; a++) mem_s[a] = 8'(a);
    endtask

    task automatic fill_random;
        for (int a = 0; a < W*H; a++) mem_s[a] = 8'($urandom_range(0, 255));
    endtask

    // Reference: windows in raster order, reads TL,TR,BL,BR, result = truncated mean of the four pixels.
    task automatic build_model;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int r = 0; r < H/2; r++) begin
            for (int c = 0; c < W/2; c++) begin
                int b, sum;
                b = 2*r*W + 2*c;
                exp_rd.push_back(b); exp_rd.push_back(b+1);
                exp_rd.push_back(b+W); exp_rd.push_back(b+W+1);
                sum = int'(mem_s[b]) + int'(mem_s[b+1]) + int'(mem_s[b+W]) + int'(mem_s[b+W+1]);
                exp_wa.push_back(r*(W/2) + c);
                exp_wd.push_back(sum / 4);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1;
        tick; tick;
        n_checks++;
        if ({busy_s, done_s, src_rd_en_s, dst_wr_en_s, src_rd_addr_s, dst_wr_addr_s} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0", {busy_s, done_s, src_rd_en_s, dst_wr_en_s, src_rd_addr_s, dst_wr_addr_s});
        end
        n_checks++;
        if ({a1_s, a2_s, a3_s, a4_s} !== 32'h0) begin
            n_fail++; $display("FAIL reset_avg_in: got %h required 0", {a1_s, a2_s, a3_s, a4_s});
        end
        n_checks++;
        if ({busy_b, done_b, src_rd_en_b, dst_wr_en_b, src_rd_addr_b, dst_wr_addr_b} !== '0) begin
            n_fail++; $display("FAIL reset_big: got %b required 0", {busy_b, done_b, src_rd_en_b, dst_wr_en_b, src_rd_addr_b, dst_wr_addr_b});
        end
        reset = 1'b0; start = 1'b0;
        tick; tick;
        n_checks++;
        if (busy_s !== 1'b0 || src_rd_en_s !== 1'b0) begin
            n_fail++; $display("FAIL start_with_reset: busy=%b rd_en=%b required 0 0", busy_s, src_rd_en_s);
        end
    endtask

    task automatic test_basic_frame;
        int s; bit seen;
        int e_rd[16] = '{0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15};
        int e_wa[4]  = '{0,1,2,3};
        int e_wd[4]  = '{2,4,10,12};
        fill_ident; clear_log;
        pulse_start(s);
        n_checks++;
        if (busy_s !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b required 1", busy_s); end
        wait_done(60, seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL basic_done_seen: got 0 required 1"); end
        n_checks++;
        if (first_rd - s !== 1) begin n_fail++; $display("FAIL basic_first_rd: got %0d required 1", first_rd - s); end
        n_checks++;
        if (done_cyc - first_rd !== 24) begin n_fail++; $display("FAIL basic_done_latency: got %0d required 24", done_cyc - first_rd); end
        n_checks++;
        if (busy_at_done !== 1'b0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL basic_busy_low: got %b/%b required 0/0", busy_at_done, busy_s); end
        n_checks++;
        if (rd_q.size() != 16 || wa_q.size() != 4 || done_n != 1) begin
            n_fail++; $display("FAIL basic_counts: reads=%0d writes=%0d dones=%0d required 16 4 1", rd_q.size(), wa_q.size(), done_n);
        end
        for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
            n_checks++;
            if (rd_q[i] != e_rd[i]) begin n_fail++; $display("FAIL read_order[%0d]: got %0d required %0d", i, rd_q[i], e_rd[i]); end
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] != e_wa[i] || wd_q[i] != e_wd[i]) begin
                n_fail++; $display("FAIL basic_write[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wa_q[i], wd_q[i], e_wa[i], e_wd[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int s; bit seen;
        int e_wd[4] = '{2,4,10,12};
        fill_ident; clear_log;
        pulse_start(s);
        repeat (3) tick;
        start = 1'b1; tick; start = 1'b0;
        repeat (6) tick;
        start = 1'b1; tick; start = 1'b0;
        wait_done(60, seen);
        repeat (10) tick;
        n_checks++;
        if (!seen || done_n != 1 || done_cyc - first_rd != 24) begin
            n_fail++; $display("FAIL busy_start_done: dones=%0d latency=%0d required 1 24", done_n, done_cyc - first_rd);
        end
        n_checks++;
        if (wa_q.size() != 4 || rd_q.size() != 16) begin
            n_fail++; $display("FAIL busy_start_counts: writes=%0d reads=%0d required 4 16", wa_q.size(), rd_q.size());
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] != i || wd_q[i] != e_wd[i]) begin
                n_fail++; $display("FAIL busy_start_write[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wa_q[i], wd_q[i], i, e_wd[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int s; bit seen;
        int e_wd[4] = '{2,4,10,12};
        fill_ident; clear_log;
        pulse_start(s);
        repeat (7) tick;
        n_checks++;
        if (src_rd_en_s !== 1'b1 || src_rd_addr_s !== 4'd3) begin
            n_fail++; $display("FAIL midreset_pre: rd_en=%b addr=%0d required 1 3", src_rd_en_s, src_rd_addr_s);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy_s, done_s, src_rd_en_s, dst_wr_en_s, src_rd_addr_s, dst_wr_addr_s, a1_s, a2_s, a3_s, a4_s} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h required 0",
                {busy_s, done_s, src_rd_en_s, dst_wr_en_s, src_rd_addr_s, dst_wr_addr_s, a1_s, a2_s, a3_s, a4_s});
        end
        clear_log;
        tick; tick;
        reset = 1'b0;
        repeat (30) tick;
        n_checks++;
        if (done_n != 0 || rd_q.size() != 0 || wa_q.size() != 0) begin
            n_fail++; $display("FAIL midreset_quiet: dones=%0d reads=%0d writes=%0d required 0 0 0", done_n, rd_q.size(), wa_q.size());
        end
        clear_log;
        pulse_start(s);
        wait_done(60, seen);
        n_checks++;
        if (!seen || done_n != 1 || done_cyc - first_rd != 24 || wa_q.size() != 4) begin
            n_fail++; $display("FAIL midreset_rerun: dones=%0d latency=%0d writes=%0d required 1 24 4", done_n, done_cyc - first_rd, wa_q.size());
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] != i || wd_q[i] != e_wd[i]) begin
                n_fail++; $display("FAIL midreset_write[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wa_q[i], wd_q[i], i, e_wd[i]);
            end
        end
    endtask

`ifdef POOL_BACKPRESSURE_EN
    task automatic test_backpressure;
        int s; bit seen;
        int e_wd[4] = '{2,4,10,12};
        fill_ident; clear_log;
        dst_ready = 1'b0;
        pulse_start(s);
        repeat (5) tick;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({dst_wr_en_s, dst_wr_addr_s, dst_wr_data_s} !== {1'b1, 2'd0, 8'd2} || wa_q.size() != 0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got en=%b addr=%0d data=%0d writes=%0d required 1 0 2 0",
                    j, dst_wr_en_s, dst_wr_addr_s, dst_wr_data_s, wa_q.size());
            end
            tick;
        end
        dst_ready = 1'b1;
        wait_done(60, seen);
        n_checks++;
        if (!seen || done_cyc - first_rd != 27) begin
            n_fail++; $display("FAIL bp_done_latency: got %0d required 27", done_cyc - first_rd);
        end
        n_checks++;
        if (wa_q.size() != 4) begin n_fail++; $display("FAIL bp_write_count: got %0d required 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] != i || wd_q[i] != e_wd[i]) begin
                n_fail++; $display("FAIL bp_write[%0d]: got (%0d,%0d) required (%0d,%0d)", i, wa_q[i], wd_q[i], i, e_wd[i]);
            end
        end
    endtask
`endif

    task automatic test_random_frames;
        int s, bad; bit seen;
        for (int it = 0; it < 4; it++) begin
            fill_random; build_model; clear_log;
            pulse_start(s);
            wait_done(60, seen);
            n_checks++;
            if (!seen || done_n != 1 || done_cyc - first_rd != 24) begin
                n_fail++; $display("FAIL rand_done[%0d]: dones=%0d latency=%0d required 1 24", it, done_n, done_cyc - first_rd);
            end
            bad = (rd_q.size() != exp_rd.size()) ? 1 : 0;
            for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) if (rd_q[i] != exp_rd[i]) bad++;
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL rand_reads[%0d]: got %0d bad reads of %0d required 0", it, bad, rd_q.size()); end
            bad = (wa_q.size() != exp_wa.size()) ? 1 : 0;
            for (int i = 0; i < wa_q.size() && i < exp_wa.size(); i++) begin
                if (wa_q[i] != exp_wa[i] || wd_q[i] != exp_wd[i]) begin
                    bad++;
                    $display("  rand[%0d] write %0d: got (%0d,%0d) want (%0d,%0d)", it, i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
                end
            end
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL rand_writes[%0d]: got %0d bad writes required 0", it, bad); end
        end
    endtask

    task automatic test_back_to_back;
        int s, bad; bit seen, hit;
        fill_random; build_model; clear_log;
        pulse_start(s);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick;
            if (done_s === 1'b1) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL b2b_done_seen: got 0 required 1"); end
        start = 1'b1; tick; start = 1'b0;
        n_checks++;
        if (busy_s !== 1'b0 || src_rd_en_s !== 1'b0) begin
            n_fail++; $display("FAIL b2b_start_in_done: busy=%b rd_en=%b required 0 0", busy_s, src_rd_en_s);
        end
        tick;
        n_checks++;
        if (busy_s !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after_done: busy=%b required 0", busy_s); end
        fill_random; build_model; clear_log;
        pulse_start(s);
        wait_done(60, seen);
        bad = (wa_q.size() != exp_wa.size() || !seen) ? 1 : 0;
        for (int i = 0; i < wa_q.size() && i < exp_wa.size(); i++)
            if (wa_q[i] != exp_wa[i] || wd_q[i] != exp_wd[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_second_frame: got %0d bad writes required 0", bad); end
    endtask

    task automatic test_big_frame;
        int s, bad;
        bit seen;
        wa_b.delete(); wd_b.delete(); done_n_b = 0; done_cyc_b = -1;
        s = cyc;
        start_b = 1'b1; tick; start_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1400 && !seen; i++) begin
            tick;
            if (done_n_b > 0) seen = 1'b1;
        end
        tick;
        n_checks++;
        if (!seen || done_cyc_b - s != 1177) begin
            n_fail++; $display("FAIL big_done_latency: got %0d required 1177", done_cyc_b - s);
        end
        n_checks++;
        if (wa_b.size() != 196) begin n_fail++; $display("FAIL big_write_count: got %0d required 196", wa_b.size()); end
        n_checks++;
        if (wa_b.size() == 0 || wa_b[wa_b.size()-1] != 195 || wd_b[wd_b.size()-1] != 128) begin
            n_fail++; $display("FAIL big_last_write: got (%0d,%0d) required (195,128)",
                (wa_b.size() > 0) ? wa_b[wa_b.size()-1] : -1, (wd_b.size() > 0) ? wd_b[wd_b.size()-1] : -1);
        end
        bad = 0;
        for (int i = 0; i < wa_b.size(); i++) begin
            int r, c, b, e;
            r = i / 14; c = i % 14;
            b = 2*r*28 + 2*c;
            e = ((b % 256) + ((b+1) % 256) + ((b+28) % 256) + ((b+29) % 256)) / 4;
            if (wa_b[i] != i || wd_b[i] != e) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL big_all_writes: got %0d bad writes required 0", bad); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_frame;
        test_start_while_busy;
        test_reset_mid_frame;
`ifdef POOL_BACKPRESSURE_EN
        test_backpressure;
`endif
        test_random_frames;
        test_back_to_back;
        test_big_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
